// File: rtl/fifo_pkg.sv
// Shared definitions for the common-clock FIFO wrapper and its storage array.
// Holds the pointer/count width helper and the recognised storage selector strings.
package fifo_pkg;

  // Storage selector that maps the array onto the 512x256 dual-port SRAM macro.
  localparam string CFG_SRAM_DPW512_D256 = "SRAMdpw512d256";

  // Pointer and occupancy width: address bits plus one wrap bit.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sram_1r1w.sv
// 1R1W storage array with synchronous write, synchronous read and a read-data register.
// MANUAL_CONFIG picks the SRAM macro mapping or a generic register array; both behave identically.
module fifo_sram_1r1w
  import fifo_pkg::*;
#(
  parameter int    WIDTH         = 512,
  parameter int    DEPTH         = 256,
  parameter string MANUAL_CONFIG = "",
  localparam int   AW            = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] rd_word_s;
  logic [WIDTH-1:0] rdata_q;

  if (MANUAL_CONFIG == CFG_SRAM_DPW512_D256) begin : g_macro
    // Behavioural view of the SRAMdpw512d256 macro; the physical flow binds the hard cell here.
    logic [WIDTH-1:0] macro_mem_q [DEPTH];

    // Macro write port: store wdata at waddr on an enabled write.
    always_ff @(posedge clk) begin
      if (we) begin
        macro_mem_q[waddr] <= wdata;
      end
    end

    assign rd_word_s = macro_mem_q[raddr];
  end else begin : g_regs
    logic [WIDTH-1:0] reg_mem_q [DEPTH];

    // Register-array write port: store wdata at waddr on an enabled write.
    always_ff @(posedge clk) begin
      if (we) begin
        reg_mem_q[waddr] <= wdata;
      end
    end

    assign rd_word_s = reg_mem_q[raddr];
  end

  // Read-data register: captures the addressed word on a read and holds it otherwise.
  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rd_word_s;
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/common_clk_bram_fifo_to_asic_fifo_wrapper.sv
// Single-clock standard-read-mode FIFO with a common-clock BRAM FIFO style interface.
// Pointers carry a wrap bit; all flags decode from the registered pointers only.
// Optional macro FIFO_ASSERT_EN compiles in simulation assertions (fifo_assert_chk).
module common_clk_bram_fifo_to_asic_fifo_wrapper
  import fifo_pkg::*;
#(
  parameter int    WIDTH         = 512,
  parameter int    DEPTH         = 256,
  parameter int    OUTPUT_DELAY  = 1,
  parameter string MANUAL_CONFIG = "",
  localparam int   CW            = fifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    data_count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             half_full
);

  localparam int AW = CW - 1;

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_s;
  logic             full_s, empty_s;
  logic             wr_acc_s, rd_acc_s;
  logic [WIDTH-1:0] sram_rdata_s;

  // Occupancy and flags come straight from the registered pointers.
  assign count_s  = wr_ptr_q - rd_ptr_q;
  assign full_s   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign wr_acc_s = wr_en && !full_s;
  assign rd_acc_s = rd_en && !empty_s;

  // Next-pointer logic: advance each pointer only on an accepted access.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers with synchronous reset taking priority over accesses.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign full         = full_s;
  assign empty        = empty_s;
  assign data_count   = count_s;
  assign almost_full  = (count_s >= CW'(DEPTH - 1));
  assign almost_empty = (count_s <= CW'(1));
  assign half_full    = (count_s >= CW'(DEPTH / 2));

  fifo_sram_1r1w #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .MANUAL_CONFIG(MANUAL_CONFIG)
  ) u_sram (
    .clk  (clk),
    .srst (srst),
    .we   (wr_acc_s),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(din),
    .re   (rd_acc_s),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(sram_rdata_s)
  );

  if (OUTPUT_DELAY > 1) begin : g_pipe
    logic [WIDTH-1:0] pipe_q [OUTPUT_DELAY-1];

    // Extra output stages shift every cycle, so a held SRAM word keeps dout stable.
    always_ff @(posedge clk) begin
      if (srst) begin
        for (int i = 0; i < OUTPUT_DELAY - 1; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= sram_rdata_s;
        for (int i = 1; i < OUTPUT_DELAY - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign dout = pipe_q[OUTPUT_DELAY-2];
  end else begin : g_nopipe
    assign dout = sram_rdata_s;
  end

`ifdef FIFO_ASSERT_EN
  fifo_assert_chk #(
    .DEPTH       (DEPTH),
    .OUTPUT_DELAY(OUTPUT_DELAY),
    .CW          (CW)
  ) u_chk (
    .clk       (clk),
    .srst      (srst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .full      (full_s),
    .empty     (empty_s),
    .data_count(count_s)
  );
`endif

endmodule

`ifdef FIFO_ASSERT_EN
// Simulation-only checks on configuration and on the FIFO handshake.
module fifo_assert_chk #(
  parameter int DEPTH        = 256,
  parameter int OUTPUT_DELAY = 1,
  parameter int CW           = 9
) (
  input logic          clk,
  input logic          srst,
  input logic          wr_en,
  input logic          rd_en,
  input logic          full,
  input logic          empty,
  input logic [CW-1:0] data_count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (OUTPUT_DELAY < 1) begin : g_bad_delay
    $error("fifo: OUTPUT_DELAY must be >= 1");
  end

  a_no_overflow: assert property (@(posedge clk) !(!srst && wr_en && full))
    else $error("fifo: write while full");
  a_no_underflow: assert property (@(posedge clk) !(!srst && rd_en && empty))
    else $error("fifo: read while empty");
  a_count_range: assert property (@(posedge clk) data_count <= CW'(DEPTH))
    else $error("fifo: data_count exceeds DEPTH");

endmodule
`endif

// File: tb/tb_common_clk_bram_fifo_to_asic_fifo_wrapper.sv
// Directed bench: a vector table for basic sequencing plus hand-written fill/drain,
// threshold, simultaneous access, reset and OUTPUT_DELAY=3 latency sequences.
module tb_common_clk_bram_fifo_to_asic_fifo_wrapper;

  localparam int W  = 512;
  localparam int D  = 256;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          srst;
  logic [W-1:0]  din;
  logic          wr_en, rd_en;
  logic [W-1:0]  dout;
  logic          full, empty, almost_full, almost_empty, half_full;
  logic [CW-1:0] data_count;

  logic [15:0]   din3, dout3;
  logic          wr3, rd3;
  logic          full3, empty3, af3, ae3, hf3;
  logic [3:0]    cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  common_clk_bram_fifo_to_asic_fifo_wrapper #(
    .WIDTH(W), .DEPTH(D), .OUTPUT_DELAY(1), .MANUAL_CONFIG("SRAMdpw512d256")
  ) u_dut (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .data_count(data_count),
    .almost_full(almost_full), .almost_empty(almost_empty), .half_full(half_full)
  );

  common_clk_bram_fifo_to_asic_fifo_wrapper #(
    .WIDTH(16), .DEPTH(8), .OUTPUT_DELAY(3), .MANUAL_CONFIG("")
  ) u_dut3 (
    .clk(clk), .srst(srst), .din(din3), .wr_en(wr3), .rd_en(rd3),
    .dout(dout3), .full(full3), .empty(empty3), .data_count(cnt3),
    .almost_full(af3), .almost_empty(ae3), .half_full(hf3)
  );

  typedef struct {
    logic        srst;
    logic        wr;
    logic        rd;
    logic [31:0] din;
    int          cnt;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl [10];
  logic [31:0] model_q [$];
  logic [31:0] exp_w;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input int c);
    chk({tag, ".data_count"}, W'(data_count), W'(c));
    chk({tag, ".empty"}, W'(empty), W'(c == 0));
    chk({tag, ".full"}, W'(full), W'(c == D));
    chk({tag, ".almost_empty"}, W'(almost_empty), W'(c <= 1));
    chk({tag, ".almost_full"}, W'(almost_full), W'(c >= D - 1));
    chk({tag, ".half_full"}, W'(half_full), W'(c >= D / 2));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    wr3 = 1'b0; rd3 = 1'b0; din3 = 16'h0;

    // Reset held for two cycles.
    step(); step();
    srst = 1'b0;
    chk("reset.dout", dout, '0);
    chk_flags("reset", 0);

    // Short sequence: writes, reads, underflow, write+read on empty, reset.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h11, 1, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h22, 2, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0,  1, 32'h11};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h33, 1, 32'h22};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,  1, 32'h22};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0,  0, 32'h33};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0,  0, 32'h33};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h44, 1, 32'h33};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h0,  0, 32'h44};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 32'h55, 0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      srst  = tbl[i].srst;
      wr_en = tbl[i].wr;
      rd_en = tbl[i].rd;
      din   = W'(tbl[i].din);
      step();
      chk_flags($sformatf("vec%0d", i), tbl[i].cnt);
      chk($sformatf("vec%0d.dout", i), dout, W'(tbl[i].dout));
    end
    srst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    // Fill 0..255, checking every threshold as occupancy climbs.
    for (int i = 0; i < D; i++) begin
      wr_en = 1'b1;
      din   = W'(i);
      step();
      chk_flags($sformatf("fill%0d", i + 1), i + 1);
    end

    // Overflow attempt is ignored.
    din = W'(32'hA5);
    step();
    wr_en = 1'b0;
    chk_flags("overflow", D);

    // Drain: data in order, one cycle after each read.
    rd_en = 1'b1;
    for (int i = 0; i < D; i++) begin
      step();
      chk($sformatf("drain%0d.dout", i), dout, W'(i));
      chk($sformatf("drain%0d.count", i), W'(data_count), W'(D - 1 - i));
    end
    rd_en = 1'b0;
    chk_flags("drained", 0);

    // Underflow: dout holds the last word, count stays 0.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("underflow.dout", dout, W'(D - 1));
    chk_flags("underflow", 0);

    // Simultaneous read/write at count 10 (pointers have already wrapped once).
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      din   = W'(100 + i);
      model_q.push_back(32'(100 + i));
      step();
    end
    chk_flags("prefill10", 10);
    rd_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      din = W'(200 + j);
      step();
      exp_w = model_q.pop_front();
      model_q.push_back(32'(200 + j));
      chk($sformatf("simul%0d.dout", j), dout, W'(exp_w));
      chk($sformatf("simul%0d.count", j), W'(data_count), W'(10));
    end
    rd_en = 1'b0;

    // Grow to 50 entries then reset mid-run.
    for (int i = 0; i < 40; i++) begin
      din = W'(300 + i);
      step();
    end
    wr_en = 1'b0;
    chk_flags("count50", 50);
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk_flags("midreset", 0);
    chk("midreset.dout", dout, '0);

    // OUTPUT_DELAY=3 instance: three words then latency checks.
    for (int i = 0; i < 3; i++) begin
      wr3  = 1'b1;
      din3 = 16'hBEE0 + 16'(i);
      step();
    end
    wr3 = 1'b0;
    chk("d3.count3", W'(cnt3), W'(3));
    rd3 = 1'b1;
    step();
    rd3 = 1'b0;
    chk("d3.lat1", W'(dout3), W'(16'h0));
    step();
    chk("d3.lat2", W'(dout3), W'(16'h0));
    step();
    chk("d3.lat3", W'(dout3), W'(16'hBEE0));
    rd3 = 1'b1;
    step();
    chk("d3.b2b1", W'(dout3), W'(16'hBEE0));
    step();
    rd3 = 1'b0;
    chk("d3.b2b2", W'(dout3), W'(16'hBEE0));
    step();
    chk("d3.b2b3", W'(dout3), W'(16'hBEE1));
    step();
    chk("d3.b2b4", W'(dout3), W'(16'hBEE2));
    step();
    chk("d3.hold", W'(dout3), W'(16'hBEE2));
    chk("d3.empty", W'(empty3), W'(1'b1));
    chk("d3.count0", W'(cnt3), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
